// File: rtl/decoder38_scan.sv
// 3-to-8 decoder with active-low one-hot output, cascade enable and an
// optional self-scanning mode that walks the code 0..7 at a divided rate.
// Every output comes straight from a flop, so there is no combinational
// path from any input to any output.
module decoder38_scan #(
  // Number of clock cycles each code is held in scan mode (1..255).
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [2:0] iData,
  input  logic       iValid,
  input  logic       iEI,
  input  logic       iScan,
  output logic [7:0] oData,
  output logic [2:0] oCode,
  output logic       oEO,
  output logic       oWrap
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  state_t     state_q, state_d;
  logic [2:0] code_q,  code_d;
  logic [7:0] div_q,   div_d;
  // Set while the output must stay blank after coming back from OFF,
  // cleared by the first direct load or by entering scan mode.
  logic       blank_q, blank_d;
  logic [7:0] data_q,  data_d;
  logic       eo_q,    eo_d;
  logic       wrap_q,  wrap_d;

  // Next-state and next-output logic; disable beats scan, scan beats direct.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    div_d   = div_q;
    blank_d = blank_q;
    data_d  = 8'hFF;
    eo_d    = 1'b0;
    wrap_d  = 1'b0;

    if (iEI) begin
      // Disabled: code and divider frozen, outputs blanked, enable-out low
      // so a cascaded partner takes over.
      state_d = ST_OFF;
      blank_d = 1'b1;
    end else if (iScan) begin
      state_d = ST_SCAN;
      eo_d    = 1'b1;
      blank_d = 1'b0;
      if (state_q != ST_SCAN) begin
        // Entering scan restarts the divider but keeps the current code.
        div_d = 8'd0;
      end else if (div_q == DIV_LAST) begin
        div_d  = 8'd0;
        code_d = code_q + 3'd1;
        wrap_d = (code_q == 3'd7);
      end else begin
        div_d = div_q + 8'd1;
      end
      data_d = ~(8'd1 << code_d);
    end else begin
      state_d = ST_DIRECT;
      eo_d    = 1'b1;
      if (iValid) begin
        code_d  = iData;
        blank_d = 1'b0;
      end
      data_d = blank_d ? 8'hFF : ~(8'd1 << code_d);
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= ST_OFF;
      code_q  <= 3'd0;
      div_q   <= 8'd0;
      blank_q <= 1'b1;
      data_q  <= 8'hFF;
      eo_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      div_q   <= div_d;
      blank_q <= blank_d;
      data_q  <= data_d;
      eo_q    <= eo_d;
      wrap_q  <= wrap_d;
    end
  end

  assign oData = data_q;
  assign oCode = code_q;
  assign oEO   = eo_q;
  assign oWrap = wrap_q;

endmodule

// File: tb/tb_decoder38_scan.sv
// Self-checking bench for decoder38_scan: direct/disable vector table,
// scan sequences for SCAN_DIV=4 and SCAN_DIV=1, reset mid-scan and a
// two-instance 4-to-16 cascade sweep.
module tb_decoder38_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: SCAN_DIV=4
  logic       a_rst_n, a_v, a_ei, a_sc;
  logic [2:0] a_d;
  logic [7:0] a_data;
  logic [2:0] a_code;
  logic       a_eo, a_wrap;

  // DUT B: SCAN_DIV=1
  logic       b_rst_n, b_v, b_ei, b_sc;
  logic [2:0] b_d;
  logic [7:0] b_data;
  logic [2:0] b_code;
  logic       b_eo, b_wrap;

  // Cascade pair
  logic       c_rst_n, c_v, c_b3;
  logic [2:0] c_d;
  logic [7:0] lo_data, hi_data;
  logic [2:0] lo_code, hi_code;
  logic       lo_eo, hi_eo, lo_wrap, hi_wrap;

  decoder38_scan #(.SCAN_DIV(4)) dut_a (
    .iClk(clk), .iRst_n(a_rst_n), .iData(a_d), .iValid(a_v), .iEI(a_ei),
    .iScan(a_sc), .oData(a_data), .oCode(a_code), .oEO(a_eo), .oWrap(a_wrap));

  decoder38_scan #(.SCAN_DIV(1)) dut_b (
    .iClk(clk), .iRst_n(b_rst_n), .iData(b_d), .iValid(b_v), .iEI(b_ei),
    .iScan(b_sc), .oData(b_data), .oCode(b_code), .oEO(b_eo), .oWrap(b_wrap));

  decoder38_scan #(.SCAN_DIV(4)) dut_lo (
    .iClk(clk), .iRst_n(c_rst_n), .iData(c_d), .iValid(c_v), .iEI(c_b3),
    .iScan(1'b0), .oData(lo_data), .oCode(lo_code), .oEO(lo_eo), .oWrap(lo_wrap));

  decoder38_scan #(.SCAN_DIV(4)) dut_hi (
    .iClk(clk), .iRst_n(c_rst_n), .iData(c_d), .iValid(c_v), .iEI(lo_eo),
    .iScan(1'b0), .oData(hi_data), .oCode(hi_code), .oEO(hi_eo), .oWrap(hi_wrap));

  typedef struct {
    int         sel;   // 0 = DUT A, 1 = DUT B
    logic [7:0] data;
    logic [2:0] code;
    logic       eo;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic [2:0] d;
    logic       v;
    logic       ei;
    logic       sc;
    logic [7:0] e_data;
    logic [2:0] e_code;
    logic       e_eo;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   txn     = 0;

  function automatic logic [7:0] oh(input int c);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << c);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %h expected %h", nm, txn, act, exp);
    end
  endtask

  // Push the expectation, let the edge happen, then pop and compare.
  task automatic cycle_check(input exp_t e);
    exp_t g;
    logic [7:0] d;
    logic [2:0] c;
    logic       eo, w;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    if (g.sel == 0) begin
      d = a_data; c = a_code; eo = a_eo; w = a_wrap;
    end else begin
      d = b_data; c = b_code; eo = b_eo; w = b_wrap;
    end
    txn++;
    $display("[TB] txn %0d dut%0d data=%h code=%0d eo=%b wrap=%b", txn, g.sel, d, c, eo, w);
    chk("data", {8'h0, d}, {8'h0, g.data});
    chk("code", {13'h0, c}, {13'h0, g.code});
    chk("eo",   {15'h0, eo}, {15'h0, g.eo});
    chk("wrap", {15'h0, w}, {15'h0, g.wrap});
  endtask

  function automatic exp_t mk(input int sel, input logic [7:0] d, input int c,
                              input logic eo, input logic w);
    exp_t e;
    e.sel = sel; e.data = d; e.code = 3'(c); e.eo = eo; e.wrap = w;
    return e;
  endfunction

  function automatic vec_t mv(input int d, input logic v, input logic ei, input logic sc,
                              input logic [7:0] ed, input int ec, input logic eeo);
    vec_t x;
    x.d = 3'(d); x.v = v; x.ei = ei; x.sc = sc;
    x.e_data = ed; x.e_code = 3'(ec); x.e_eo = eeo;
    return x;
  endfunction

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    a_rst_n = 1'b0; a_v = 1'b1; a_ei = 1'b0; a_sc = 1'b1; a_d = 3'd5;
    b_rst_n = 1'b0; b_v = 1'b0; b_ei = 1'b0; b_sc = 1'b0; b_d = 3'd0;
    c_rst_n = 1'b0; c_v = 1'b0; c_b3 = 1'b0; c_d = 3'd0;

    // Reset dominates active inputs.
    cycle_check(mk(0, 8'hFF, 0, 1'b0, 1'b0));
    a_rst_n = 1'b1;

    // Direct / disable vector table.
    vt.push_back(mv(3, 1'b0, 1'b0, 1'b0, 8'hFF, 0, 1'b1));   // from OFF, no load yet
    for (int i = 0; i < 8; i++)
      vt.push_back(mv(i, 1'b1, 1'b0, 1'b0, oh(i), i, 1'b1)); // direct sweep
    vt.push_back(mv(2, 1'b0, 1'b0, 1'b0, 8'h7F, 7, 1'b1));   // hold
    vt.push_back(mv(5, 1'b1, 1'b0, 1'b0, 8'hDF, 5, 1'b1));
    vt.push_back(mv(0, 1'b0, 1'b1, 1'b0, 8'hFF, 5, 1'b0));   // disable
    vt.push_back(mv(2, 1'b1, 1'b1, 1'b0, 8'hFF, 5, 1'b0));   // OFF beats load
    vt.push_back(mv(1, 1'b0, 1'b0, 1'b0, 8'hFF, 5, 1'b1));   // still blank
    vt.push_back(mv(5, 1'b1, 1'b0, 1'b0, 8'hDF, 5, 1'b1));   // load restores
    for (int i = 0; i < vt.size(); i++) begin
      a_d = vt[i].d; a_v = vt[i].v; a_ei = vt[i].ei; a_sc = vt[i].sc;
      cycle_check(mk(0, vt[i].e_data, int'(vt[i].e_code), vt[i].e_eo, 1'b0));
    end

    // Scan wrap from reset, iValid/iData ignored; then reset at code 6.
    a_rst_n = 1'b0;
    cycle_check(mk(0, 8'hFF, 0, 1'b0, 1'b0));
    a_rst_n = 1'b1; a_ei = 1'b0; a_sc = 1'b1; a_v = 1'b1; a_d = 3'd3;
    for (k = 0; k <= 56; k++)
      cycle_check(mk(0, oh((k / 4) % 8), (k / 4) % 8, 1'b1, k == 32));
    a_rst_n = 1'b0;
    cycle_check(mk(0, 8'hFF, 0, 1'b0, 1'b0));
    a_rst_n = 1'b1;

    // Scan to code 2, freeze in direct, re-enter scan from DIRECT.
    for (k = 0; k < 10; k++)
      cycle_check(mk(0, oh(k / 4), k / 4, 1'b1, 1'b0));
    a_sc = 1'b0; a_v = 1'b0;
    cycle_check(mk(0, oh(2), 2, 1'b1, 1'b0));
    cycle_check(mk(0, oh(2), 2, 1'b1, 1'b0));
    a_sc = 1'b1;
    for (k = 0; k < 5; k++)
      cycle_check(mk(0, oh(2 + k / 4), 2 + k / 4, 1'b1, 1'b0));
    // Disable mid-scan holds code; re-enter scan from OFF continues from it.
    a_ei = 1'b1;
    cycle_check(mk(0, 8'hFF, 3, 1'b0, 1'b0));
    a_ei = 1'b0;
    for (k = 0; k < 5; k++)
      cycle_check(mk(0, oh(3 + k / 4), 3 + k / 4, 1'b1, 1'b0));

    // SCAN_DIV=1: advance every cycle, wrap every 8.
    cycle_check(mk(1, 8'hFF, 0, 1'b0, 1'b0));
    b_rst_n = 1'b1; b_sc = 1'b1;
    for (k = 0; k <= 16; k++)
      cycle_check(mk(1, oh(k % 8), k % 8, 1'b1, (k == 8) || (k == 16)));

    // 4-to-16 cascade sweep.
    @(posedge clk); #1;
    c_rst_n = 1'b1; c_v = 1'b1;
    for (int code = 0; code < 16; code++) begin
      logic [15:0] one16, exp16, got16;
      c_d  = 3'(code);
      c_b3 = code[3];
      @(posedge clk); #1;
      @(posedge clk); #1;
      one16 = 16'd1;
      exp16 = ~(one16 << code);
      got16 = {hi_data, lo_data};
      txn++;
      $display("[TB] txn %0d cascade code=%0d out=%h", txn, code, got16);
      chk("cascade", got16, exp16);
      chk("cascade_onehot", 16'($countones(~got16)), 16'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder38_scan.md
DECODER38_SCAN -- requirements
Module: decoder38_scan

Interface
REQ-001 The block SHALL have one parameter: SCAN_DIV, default 4, clock cycles each code is held in scan mode (legal 1..255).
REQ-002 The block SHALL have these ports:
- iClk  input  1  single clock; all state updates on the rising edge.
- iRst_n  input  1  synchronous, active-low reset.
- iData  input  3  binary code to decode in direct mode.
- iValid  input  1  high: iData is loaded in direct mode.
- iEI  input  1  enable, active-low; 1 disables the block.
- iScan  input  1  1 selects scan mode, 0 selects direct mode.
- oData  output  8  decoded line, active-low one-hot; 8'hFF when none is active.
- oCode  output  3  code currently decoded.
- oEO  output  1  enable-out, active-low; 0 when this block is disabled (iEI=1), for 4-16 cascade.
- oWrap  output  1  one-cycle pulse when the scan code wraps from 7 to 0.

Function
REQ-003 The block SHALL contain a registered FSM with three states: OFF, DIRECT and SCAN.
REQ-004 FSM transitions SHALL be evaluated every cycle, in this priority:
- iEI=1 -> OFF.
- otherwise iScan=1 -> SCAN.
- otherwise -> DIRECT.
REQ-005 In OFF, oData SHALL be 8'hFF, oEO SHALL be 0, and oCode and the divider counter SHALL hold their values.
REQ-006 In DIRECT and SCAN, oEO SHALL be 1.
REQ-007 In DIRECT, iValid=1 at edge N SHALL load iData into the code register, with oCode and oData reflecting it after edge N (latency 1).
REQ-008 In DIRECT, iValid=0 SHALL hold the code register.
REQ-009 Entering DIRECT from OFF SHALL leave oData at 8'hFF until the first iValid load.
REQ-010 In every state other than OFF, and outside the REQ-009 wait, oData SHALL equal the bitwise inverse of (8'b1 shifted left by oCode).
- Bit oCode is the only 0.
REQ-011 In SCAN, an 8-bit divider counter SHALL count 0..SCAN_DIV-1.
- When the counter is at SCAN_DIV-1, it SHALL return to 0 and the code register SHALL increment modulo 8.
REQ-012 oWrap SHALL be 1 for exactly the one cycle after the code register steps from 7 to 0 in SCAN, and 0 otherwise.
REQ-013 With SCAN_DIV=1, the code register SHALL advance every cycle.
REQ-014 Entering SCAN from DIRECT or OFF SHALL clear the divider counter and continue from the current oCode.
- The code does not reset.
REQ-015 In SCAN, iValid and iData SHALL be ignored.
REQ-016 Leaving SCAN for DIRECT SHALL freeze oCode at its last scanned value until the next iValid load.
REQ-017 Simultaneous iEI=1 and iValid=1 SHALL load nothing; OFF takes priority.
REQ-018 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-019 While iRst_n=0 at a rising edge, the block SHALL set all of the following, regardless of other inputs:
- state to OFF;
- code register to 0;
- divider counter to 0;
- oData to 8'hFF, oCode to 0, oEO to 0, oWrap to 0.
REQ-020 Reset asserted mid-scan SHALL take effect at that edge, with no oWrap pulse generated.
REQ-021 After iRst_n returns to 1, the first edge SHALL evaluate the REQ-004 transitions normally.

Verification
REQ-022 Direct sweep: iEI=0, iScan=0, iValid=1, iData stepped 0..7 one per cycle -> oData stepped 8'hFE, 8'hFD, ... 8'h7F one cycle later; oEO=1 throughout.
REQ-023 Disable: in DIRECT with code 5, set iEI=1 -> next cycle oData=8'hFF, oEO=0, oCode=5; set iEI=0 -> oData returns to 8'hDF only after an iValid load.
REQ-024 Scan wrap: SCAN_DIV=4, reset, then iEI=0, iScan=1 for 40 cycles ->
- each code held 4 cycles, sequence 0..7 then 0;
- oWrap is a single-cycle pulse on the cycle after the 7->0 step;
- oData always one-hot low.
REQ-025 SCAN_DIV=1: codes advance every cycle; oWrap pulses once every 8 cycles.
REQ-026 Reset mid-scan: assert iRst_n=0 while oCode=6 -> after that edge oCode=0, oData=8'hFF, oEO=0, oWrap=0.
REQ-027 Cascade: two instances share iData/iValid as the low 3 bits; the upper instance's iEI is driven by the low instance's oEO; bit 3 drives the low instance's iEI. Sweep all 16 codes -> exactly one of the 16 outputs is low and its index equals the code.
